// File: rtl/io_port_responder.sv
// Memory-mapped I/O responder: CPU register access to RX/TX byte FIFOs bridging the external pins.
// Optional interrupt output is built only when IO_IRQ_EN is defined.
module io_port_responder #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] bus_addr,
    input  logic       bus_rd_en,
    input  logic       bus_wr_en,
    input  logic [7:0] bus_wr_data,
    output logic [7:0] bus_rd_data,
    input  logic [7:0] ext_in_data,
    input  logic       ext_in_valid,
    output logic [7:0] ext_out_data,
    output logic       ext_out_valid,
    input  logic       ext_out_ready
`ifdef IO_IRQ_EN
    ,
    output logic       irq
`endif
);

    localparam int DATA_W = 8;
    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_TXCNT  = 2'd2,
        REG_CTRL   = 2'd3
    } reg_addr_t;

    logic [DATA_W-1:0] rx_mem [DEPTH];
    logic [DATA_W-1:0] tx_mem [DEPTH];
    logic [PW-1:0]     rx_rd_ptr, rx_wr_ptr, tx_rd_ptr, tx_wr_ptr;
    logic [CW-1:0]     rx_cnt, tx_cnt;
    logic              rx_ovf, tx_ovf;
    logic              loopback, irq_en;

    logic              rx_empty, rx_full, tx_empty, tx_full;
    logic [DATA_W-1:0] rx_head, tx_head, rx_push_data, rd_mux;
    logic              wr_status, wr_ctrl, flush;
    logic              cpu_rd_pop, cpu_wr_tx, ext_pop, lb_xfer, ext_push_req;
    logic              rx_push, rx_pop, tx_push, tx_pop;
    logic              rx_ovf_set, tx_ovf_set;

    function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cnt,
                                                 input logic push, input logic pop);
        logic [CW-1:0] n;
        n = cnt;
        if (push && !pop) n = cnt + CW'(1);
        if (pop && !push) n = cnt - CW'(1);
        return n;
    endfunction

    // A full 16-entry FIFO would need 5 bits; the register field holds only 4.
    function automatic logic [3:0] sat4(input logic [CW-1:0] cnt);
        logic [4:0] wide;
        wide = 5'(cnt);
        return (wide > 5'd15) ? 4'hF : wide[3:0];
    endfunction

    assign rx_empty = (rx_cnt == '0);
    assign rx_full  = (rx_cnt == CW'(DEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign tx_full  = (tx_cnt == CW'(DEPTH));
    assign rx_head  = rx_mem[rx_rd_ptr];
    assign tx_head  = tx_mem[tx_rd_ptr];

    assign wr_status = bus_wr_en && (bus_addr == REG_STATUS);
    assign wr_ctrl   = bus_wr_en && (bus_addr == REG_CTRL);
    assign flush     = wr_ctrl && bus_wr_data[0];

    // A simultaneous write wins over the read: the RX pop side effect is suppressed.
    assign cpu_rd_pop   = bus_rd_en && !bus_wr_en && (bus_addr == REG_DATA) && !rx_empty;
    assign cpu_wr_tx    = bus_wr_en && (bus_addr == REG_DATA);
    assign ext_out_valid = !tx_empty && !loopback;
    assign ext_pop      = ext_out_valid && ext_out_ready;
    assign lb_xfer      = loopback && !tx_empty && !rx_full;
    assign ext_push_req = ext_in_valid && !loopback;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign tx_pop     = (ext_pop || lb_xfer) && !flush;
    assign tx_push    = cpu_wr_tx && (!tx_full || ext_pop || lb_xfer);
    assign tx_ovf_set = cpu_wr_tx && tx_full && !ext_pop && !lb_xfer;
    assign rx_pop     = cpu_rd_pop;
    assign rx_push    = ((ext_push_req && (!rx_full || cpu_rd_pop)) || lb_xfer) && !flush;
    assign rx_ovf_set = ext_push_req && rx_full && !cpu_rd_pop && !flush;
    assign rx_push_data = loopback ? tx_head : ext_in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_rd_ptr <= '0;
            rx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_wr_ptr <= '0;
            rx_cnt    <= '0;
            tx_cnt    <= '0;
            rx_ovf    <= 1'b0;
            tx_ovf    <= 1'b0;
            loopback  <= 1'b0;
            irq_en    <= 1'b0;
        end else begin
            if (flush) begin
                rx_rd_ptr <= '0;
                rx_wr_ptr <= '0;
                tx_rd_ptr <= '0;
                tx_wr_ptr <= '0;
                rx_cnt    <= '0;
                tx_cnt    <= '0;
            end else begin
                if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PW'(1);
                if (rx_push) rx_wr_ptr <= rx_wr_ptr + PW'(1);
                if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PW'(1);
                if (tx_push) tx_wr_ptr <= tx_wr_ptr + PW'(1);
                rx_cnt <= next_count(rx_cnt, rx_push, rx_pop);
                tx_cnt <= next_count(tx_cnt, tx_push, tx_pop);
            end
            // A new overflow in the same cycle as its W1C clear keeps the flag set.
            rx_ovf <= rx_ovf_set || (rx_ovf && !(wr_status && bus_wr_data[2]));
            tx_ovf <= tx_ovf_set || (tx_ovf && !(wr_status && bus_wr_data[3]));
            if (wr_ctrl) begin
                loopback <= bus_wr_data[1];
                irq_en   <= bus_wr_data[2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_push_data;
        if (tx_push) tx_mem[tx_wr_ptr] <= bus_wr_data;
    end

    always_comb begin
        rd_mux = '0;
        case (bus_addr)
            REG_DATA:   rd_mux = rx_empty ? '0 : rx_head;
            REG_STATUS: rd_mux = {sat4(rx_cnt), tx_ovf, rx_ovf, !tx_full, !rx_empty};
            REG_TXCNT:  rd_mux = {4'h0, sat4(tx_cnt)};
            REG_CTRL:   rd_mux = {5'b0, irq_en, loopback, 1'b0};
        endcase
    end

    assign bus_rd_data  = bus_rd_en ? rd_mux : '0;
    assign ext_out_data = tx_empty ? '0 : tx_head;

`ifdef IO_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) irq <= 1'b0;
        else     irq <= irq_en && (!rx_empty || rx_ovf || tx_ovf);
    end
`endif

endmodule

// File: tb/tb_io_port_responder.sv
// Bench for io_port_responder: RX/TX byte scoreboards plus register-value checks.
module tb_io_port_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] bus_addr;
    logic       bus_rd_en, bus_wr_en;
    logic [7:0] bus_wr_data, bus_rd_data;
    logic [7:0] ext_in_data, ext_out_data;
    logic       ext_in_valid, ext_out_valid, ext_out_ready;
`ifdef IO_IRQ_EN
    logic       irq;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] rx_exp_q[$];
    logic [7:0] tx_exp_q[$];

    io_port_responder #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .bus_addr(bus_addr), .bus_rd_en(bus_rd_en), .bus_wr_en(bus_wr_en),
        .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
        .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid),
        .ext_out_data(ext_out_data), .ext_out_valid(ext_out_valid),
        .ext_out_ready(ext_out_ready)
`ifdef IO_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
        bus_addr = addr; bus_wr_data = data; bus_wr_en = 1'b1;
        tick();
        bus_wr_en = 1'b0;
    endtask

    task automatic write_tx(input logic [7:0] data);
        tx_exp_q.push_back(data);
        bus_write(2'd0, data);
    endtask

    task automatic read_reg(input string tag, input logic [1:0] addr, input logic [7:0] exp);
        bus_addr = addr; bus_rd_en = 1'b1;
        @(negedge clk);
        check(tag, bus_rd_data, exp);
        tick();
        bus_rd_en = 1'b0;
    endtask

    task automatic read_data(input string tag);
        logic [7:0] exp;
        exp = 8'h00;
        if (rx_exp_q.size() > 0) exp = rx_exp_q.pop_front();
        read_reg(tag, 2'd0, exp);
    endtask

    task automatic ext_in(input logic [7:0] data, input bit accepted);
        if (accepted) rx_exp_q.push_back(data);
        ext_in_data = data; ext_in_valid = 1'b1;
        tick();
        ext_in_valid = 1'b0;
    endtask

    // TX scoreboard: every accepted output byte must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && ext_out_valid && ext_out_ready) begin
            if (tx_exp_q.size() == 0) check("tx_spurious", {7'b0, ext_out_valid}, 8'h00);
            else check("tx_byte", ext_out_data, tx_exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; bus_addr = '0; bus_rd_en = 0; bus_wr_en = 0; bus_wr_data = '0;
        ext_in_data = '0; ext_in_valid = 0; ext_out_ready = 0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_rd_data", bus_rd_data, 8'h00);
        check("rst_out_data", ext_out_data, 8'h00);
        check("rst_out_valid", {7'b0, ext_out_valid}, 8'h00);
`ifdef IO_IRQ_EN
        check("rst_irq", {7'b0, irq}, 8'h00);
`endif
        tick();
        read_reg("rst_status", 2'd1, 8'h02);
        read_reg("rst_ctrl", 2'd3, 8'h00);

        // Three bytes in, three bytes out, then an empty read.
        ext_in(8'h11, 1); ext_in(8'h22, 1); ext_in(8'h33, 1);
        read_reg("t1_status", 2'd1, 8'h33);
        read_data("t1_rd0"); read_data("t1_rd1"); read_data("t1_rd2");
        read_reg("t1_status_empty", 2'd1, 8'h02);
        read_data("t1_rd_empty");

        // Overflow RX, then clear rx_ovf by W1C.
        for (int i = 0; i < 5; i++) ext_in(8'hA0 + 8'(i), i < 4);
        read_reg("t2_status_full", 2'd1, 8'h47);
        bus_write(2'd1, 8'h04);
        read_reg("t2_status_w1c", 2'd1, 8'h43);

        // Full RX: strobe and pop together keep count at 4 without overflow.
        bus_addr = 2'd0; bus_rd_en = 1'b1; ext_in_data = 8'h77; ext_in_valid = 1'b1;
        begin
            logic [7:0] oldest;
            oldest = rx_exp_q.pop_front();
            rx_exp_q.push_back(8'h77);
            @(negedge clk);
            check("t4_rd_oldest", bus_rd_data, oldest);
        end
        tick();
        bus_rd_en = 1'b0; ext_in_valid = 1'b0;
        read_reg("t4_status", 2'd1, 8'h43);
        for (int i = 0; i < 4; i++) read_data("t4_drain");

        // TX path with a stalled consumer.
        write_tx(8'h5A); write_tx(8'h6B);
        @(negedge clk);
        check("t3_valid", {7'b0, ext_out_valid}, 8'h01);
        check("t3_data", ext_out_data, 8'h5A);
        read_reg("t3_txcnt", 2'd2, 8'h02);
        ext_out_ready = 1'b1;
        tick(); tick();
        ext_out_ready = 1'b0;
        @(negedge clk);
        check("t3_valid_after", {7'b0, ext_out_valid}, 8'h00);

        // TX overflow, then write accepted into a full TX during an external pop.
        for (int i = 1; i <= 4; i++) write_tx(8'(i));
        bus_write(2'd0, 8'h05);
        read_reg("tx_full_status", 2'd1, 8'h08);
        read_reg("tx_full_cnt", 2'd2, 8'h04);
        ext_out_ready = 1'b1;
        write_tx(8'h06);
        ext_out_ready = 1'b0;
        read_reg("tx_swap_cnt", 2'd2, 8'h04);
        ext_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        ext_out_ready = 1'b0;
        bus_write(2'd1, 8'h08);
        read_reg("tx_ovf_clr", 2'd1, 8'h02);

        // Read and write together: write lands in TX, RX is not popped.
        ext_in(8'h44, 1);
        bus_addr = 2'd0; bus_wr_data = 8'h55; bus_rd_en = 1'b1; bus_wr_en = 1'b1;
        tx_exp_q.push_back(8'h55);
        tick();
        bus_rd_en = 1'b0; bus_wr_en = 1'b0;
        read_reg("rw_status", 2'd1, 8'h13);
        read_reg("rw_txcnt", 2'd2, 8'h01);
        read_data("rw_rd");
        ext_out_ready = 1'b1; tick(); ext_out_ready = 1'b0;

        // Loopback: TX bytes land in RX, external input ignored.
        bus_write(2'd3, 8'h02);
        bus_addr = 2'd0; bus_wr_en = 1'b1; ext_in_valid = 1'b1;
        bus_wr_data = 8'h10; ext_in_data = 8'hEE; rx_exp_q.push_back(8'h10);
        @(negedge clk); check("t5_valid0", {7'b0, ext_out_valid}, 8'h00);
        tick();
        bus_wr_data = 8'h20; ext_in_data = 8'hEF; rx_exp_q.push_back(8'h20);
        @(negedge clk); check("t5_valid1", {7'b0, ext_out_valid}, 8'h00);
        tick();
        bus_wr_en = 1'b0; ext_in_valid = 1'b0;
        @(negedge clk); check("t5_valid2", {7'b0, ext_out_valid}, 8'h00);
        tick();
        read_reg("t5_status", 2'd1, 8'h23);
        read_data("t5_rd0"); read_data("t5_rd1");
        read_reg("t5_txcnt", 2'd2, 8'h00);
        read_reg("t5_ctrl", 2'd3, 8'h02);
        bus_write(2'd3, 8'h00);

        // Flush with both FIFOs part-filled and tx_ovf sticky.
        for (int i = 0; i < 5; i++) bus_write(2'd0, 8'hC0 + 8'(i));
        ext_in(8'h31, 0); ext_in(8'h32, 0);
        read_reg("t6_status_pre", 2'd1, 8'h29);
        bus_write(2'd3, 8'h01);
        read_reg("t6_status", 2'd1, 8'h0A);
        read_reg("t6_txcnt", 2'd2, 8'h00);
        read_reg("t6_ctrl", 2'd3, 8'h00);
        @(negedge clk); check("t6_valid", {7'b0, ext_out_valid}, 8'h00);
        tick();
        read_data("t6_rd_empty");
        bus_write(2'd1, 8'h08);
        read_reg("t6_status_clr", 2'd1, 8'h02);

        bus_write(2'd3, 8'h04);
        read_reg("ctrl_irq_en", 2'd3, 8'h04);
`ifdef IO_IRQ_EN
        @(negedge clk); check("irq_idle", {7'b0, irq}, 8'h00);
        tick();
        ext_in(8'h99, 1);
        @(negedge clk); check("irq_e1", {7'b0, irq}, 8'h00);
        tick();
        @(negedge clk); check("irq_e2", {7'b0, irq}, 8'h01);
        tick();
        read_data("irq_rd");
`endif
        bus_write(2'd3, 8'h00);

        // Reset in the middle of traffic drops everything.
        ext_in(8'h5C, 0);
        bus_write(2'd0, 8'h7D);
        rst = 1'b1;
        tick();
        @(negedge clk); check("mid_rst_valid", {7'b0, ext_out_valid}, 8'h00);
        rst = 1'b0;
        tick();
        read_reg("mid_rst_status", 2'd1, 8'h02);
        read_reg("mid_rst_txcnt", 2'd2, 8'h00);

        check("rx_q_left", 8'(rx_exp_q.size()), 8'h00);
        check("tx_q_left", 8'(tx_exp_q.size()), 8'h00);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
